// File: rtl/compuertas_pkg.sv
// Shared opcodes and FSM state encoding for the gate-unit arbiter.
package compuertas_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_XNOR = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } estado_t;

endpackage

// File: rtl/unidad_compuertas.sv
// Combinational vectorised gate unit; opcodes 6 and 7 give a zero result and raise err.
module unidad_compuertas
  import compuertas_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y,
  output logic         err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/arbitro_compuertas.sv
// Round-robin arbiter sharing one gate unit among N_REQ requesters; one transaction per 3 cycles.
//
// state | meaning
// IDLE  | waiting for a request; on a winner, latch its operands and pulse gnt
// EVAL  | gnt high; latched operands go through the gate unit
// RESP  | res_valid high with res/res_id/res_err
module arbitro_compuertas
  import compuertas_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  input  logic [N_REQ*3-1:0] op_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               res_valid,
  output logic [W-1:0]       res,
  output logic [2:0]         res_id,
  output logic               res_err
);

  estado_t          state, state_nxt;
  logic [2:0]       ptr;
  logic [W-1:0]     a_q, b_q;
  logic [2:0]       op_q;
  logic [N_REQ-1:0] rot;
  logic             win_found;
  logic [2:0]       win_idx;
  logic             load, done;
  logic [W-1:0]     y;
  logic             err;

  // Rotate so bit 0 is the requester right after the last winner.
  always_comb begin
    rot       = N_REQ'({req, req} >> (int'(ptr) + 1));
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        win_found = 1'b1;
        win_idx   = 3'((int'(ptr) + 1 + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = EVAL;
          load      = 1'b1;
        end
      end
      EVAL: begin
        state_nxt = RESP;
        done      = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      ptr       <= 3'(N_REQ - 1);
      gnt       <= '0;
      res_valid <= 1'b0;
      res       <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
    end else begin
      gnt       <= '0;
      res_valid <= 1'b0;
      if (load) begin
        a_q    <= a_in[int'(win_idx)*W +: W];
        b_q    <= b_in[int'(win_idx)*W +: W];
        op_q   <= op_in[int'(win_idx)*3 +: 3];
        gnt    <= N_REQ'(1) << win_idx;
        ptr    <= win_idx;
        res_id <= win_idx;
      end
      if (done) begin
        res       <= y;
        res_err   <= err;
        res_valid <= 1'b1;
      end
    end
  end

  unidad_compuertas #(.W(W)) u_unidad (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .y   (y),
    .err (err)
  );

endmodule

// File: tb/tb_arbitro_compuertas.sv
// Bench for arbitro_compuertas: vector table, directed corner sequences, random traffic vs. a truth-table model.
module tb_arbitro_compuertas;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic [N*3-1:0] op_in;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic [W-1:0]   res;
  logic [2:0]     res_id;
  logic           res_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arbitro_compuertas #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_in     (op_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res       (res),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  // Per-opcode truth table, bit index {a,b}.
  logic [3:0] tt [8];

  function automatic logic [W-1:0] ref_gate(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_single(input int id, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_res,
                           input logic exp_err, input bit scramble);
    a_in[id*W +: W] = a;
    b_in[id*W +: W] = b;
    op_in[id*3 +: 3] = op;
    req = 4'(1 << id);
    tick();
    chk("single_gnt", gnt, 32'(1 << id));
    chk("single_valid_early", res_valid, 0);
    req = '0;
    if (scramble) begin
      a_in[id*W +: W] = ~a;
      b_in[id*W +: W] = ~b;
      op_in[id*3 +: 3] = op ^ 3'd1;
    end
    tick();
    chk("single_valid", res_valid, 1);
    chk("single_res", res, exp_res);
    chk("single_id", res_id, id);
    chk("single_err", res_err, exp_err);
    chk("single_gnt_off", gnt, 0);
    tick();
    chk("single_valid_off", res_valid, 0);
    chk("single_res_hold", res, exp_res);
  endtask

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec_t;

  vec_t vt [10];

  // Reference model state
  int         m_ptr, busy, w;
  logic [3:0] e_gnt;
  logic       e_valid, e_err, p_err;
  logic [7:0] e_res, p_res;
  logic [2:0] e_id;

  task automatic step_model();
    if (busy == 2) begin
      e_gnt   = '0;
      e_valid = 1'b1;
      e_res   = p_res;
      e_err   = p_err;
      busy    = 1;
    end else if (busy == 1) begin
      e_valid = 1'b0;
      busy    = 0;
    end else begin
      e_valid = 1'b0;
      e_gnt   = '0;
      if (req != 0) begin
        w = 0;
        for (int k = 1; k <= N; k++) begin
          w = (m_ptr + k) % N;
          if (req[w]) break;
        end
        e_gnt = 4'(1 << w);
        e_id  = 3'(w);
        m_ptr = w;
        p_res = ref_gate(a_in[w*W +: W], b_in[w*W +: W], op_in[w*3 +: 3]);
        p_err = (op_in[w*3 +: 3] >= 3'd6);
        busy  = 2;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tt[0] = 4'b0011; tt[1] = 4'b1000; tt[2] = 4'b1110; tt[3] = 4'b0110;
    tt[4] = 4'b1001; tt[5] = 4'b0111; tt[6] = 4'b0000; tt[7] = 4'b0000;

    vt[0] = '{2, 3'd3, 8'hF0, 8'h3C, 8'hCC, 1'b0};
    vt[1] = '{0, 3'd0, 8'hAA, 8'h0F, 8'h55, 1'b0};
    vt[2] = '{1, 3'd1, 8'hAA, 8'h0F, 8'h0A, 1'b0};
    vt[3] = '{2, 3'd2, 8'hAA, 8'h0F, 8'hAF, 1'b0};
    vt[4] = '{3, 3'd3, 8'hAA, 8'h0F, 8'hA5, 1'b0};
    vt[5] = '{0, 3'd4, 8'hAA, 8'h0F, 8'h5A, 1'b0};
    vt[6] = '{1, 3'd5, 8'hAA, 8'h0F, 8'hF5, 1'b0};
    vt[7] = '{2, 3'd6, 8'hAA, 8'h0F, 8'h00, 1'b1};
    vt[8] = '{3, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vt[9] = '{1, 3'd5, 8'h00, 8'h00, 8'hFF, 1'b0};

    // Reset with all requests asserted
    rst_n = 1'b0;
    req   = 4'hF;
    a_in  = '0;
    b_in  = '0;
    op_in = '0;
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_id", res_id, 0);
    chk("rst_err", res_err, 0);

    // Round robin with req held: grants 0,1,2,3,0 every 3 cycles
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk("rr_gnt", gnt, (c % 3 == 1) ? 32'(1 << ((c / 3) % N)) : 32'd0);
      chk("rr_valid", res_valid, (c % 3 == 2) ? 32'd1 : 32'd0);
      if (c % 3 == 2) chk("rr_id", res_id, (c / 3) % N);
    end
    req = '0;

    for (int i = 0; i < 10; i++)
      do_single(vt[i].id, vt[i].op, vt[i].a, vt[i].b, vt[i].exp_res, vt[i].exp_err, 1'b0);

    // Operands change during EVAL: result uses values latched at grant
    do_single(1, 3'd1, 8'h33, 8'h55, 8'h11, 1'b0, 1'b1);

    // Reset during EVAL aborts the transaction and restores the pointer
    a_in[2*W +: W] = 8'h12;
    op_in[2*3 +: 3] = 3'd0;
    req = 4'b0100;
    tick();
    chk("abort_gnt", gnt, 32'h4);
    req   = '0;
    rst_n = 1'b0;
    #1;
    chk("abort_gnt_clr", gnt, 0);
    chk("abort_valid", res_valid, 0);
    repeat (2) begin
      tick();
      chk("abort_no_valid", res_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'hF;
    tick();
    chk("abort_ptr_gnt", gnt, 32'h1);
    req = '0;
    tick();
    chk("abort_next_valid", res_valid, 1);
    chk("abort_next_id", res_id, 0);
    tick();

    // Random traffic against the reference model
    rst_n = 1'b0;
    req   = '0;
    tick();
    @(negedge clk);
    rst_n   = 1'b1;
    m_ptr   = N - 1;
    busy    = 0;
    e_gnt   = '0;
    e_valid = 1'b0;
    e_res   = '0;
    e_id    = '0;
    e_err   = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step_model();
      tick();
      chk("rnd_gnt", gnt, e_gnt);
      chk("rnd_valid", res_valid, e_valid);
      chk("rnd_res", res, e_res);
      chk("rnd_id", res_id, e_id);
      chk("rnd_err", res_err, e_err);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          a_in[i*W +: W] = 8'($urandom);
          b_in[i*W +: W] = 8'($urandom);
          op_in[i*3 +: 3] = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
